spi_adc_reader: RTL and testbench

- SPI read master for the front-end ADC; the receive counterpart of the DAC/shift-register SPI transmit path.
- Frames an ADC conversion read by driving chip select and SCLK, shifting serial data in MSB-first, and presenting a parallel word with a one-cycle valid strobe.
- Transfers are triggered by a host pulse, or automatically from the ADC data-ready line.
- Sits beside the SPI transmit module on the same 25 MHz clock domain.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 54 +++++
 rtl/spi_adc_reader.sv | 188 ++++++++++++++++++
 tb/tb_spi_adc_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
//   Definitions shared by the SPI transfer blocks on the 25 MHz domain:
//   the transfer state encoding and the default framing constants.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    localparam int ADC_WORD_BITS    = 24;
    localparam int SPI_CLK_DIV_HALF = 2;
    localparam int ADC_CS_SETUP_CYC = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
//   Mode-0 SCLK generator. While en is high it produces bit periods made of
//   a low phase and a high phase of CLK_DIV_HALF clocks each. While en is low
//   the phase counter is held at reload and sclk is held low.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   run the generator (first enabled cycle is a low-phase cycle)
//   sclk     out  registered SPI clock
//   sample   out  last cycle of the high phase (receive capture point)
//   bit_end  out  last cycle of the current bit period
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV_HALF = SPI_CLK_DIV_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic sample,
    output logic bit_end
);

    localparam int CNT_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
    localparam logic [CNT_W-1:0] PHASE_RELOAD = CNT_W'(CLK_DIV_HALF - 1);

    logic [CNT_W-1:0] phase_cnt;
    logic             phase_tc;

    assign phase_tc = (phase_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= PHASE_RELOAD;
            sclk      <= 1'b0;
        end else if (!en) begin
            phase_cnt <= PHASE_RELOAD;
            sclk      <= 1'b0;
        end else if (phase_tc) begin
            phase_cnt <= PHASE_RELOAD;
            sclk      <= ~sclk;
        end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
        end
    end

    // A bit period is low phase then high phase, so the capture point and the
    // end of the bit fall on the same clock.
    assign sample  = en & sclk & phase_tc;
    assign bit_end = sample;

endmodule

// File: rtl/spi_adc_reader.sv
// spi_adc_reader
//   SPI read master for the front-end ADC. A host start pulse, or a falling
//   edge on the ADC data-ready line while auto_en is set, frames one read:
//   chip select low, setup delay, WORD_BITS mode-0 SCLK periods with
//   MSB-first capture, one hold cycle, then the word is published with a
//   single-cycle rx_valid strobe.
//
// Ports
//   clk25        in   25 MHz system clock
//   reset        in   asynchronous active-low reset (deasserts synchronously)
//   start        in   single-cycle read request
//   auto_en      in   allow adc_drdy falling edges to start reads
//   adc_drdy     in   ADC data-ready, active low, asynchronous
//   spi_din      in   ADC serial data, asynchronous
//   clr_overrun  in   single-cycle clear of the overrun flag
//   spi_sclk     out  SPI clock, idles low
//   adc_cs       out  ADC chip select, active low
//   rx_data      out  last completed word
//   rx_valid     out  one-cycle strobe, rx_data updated in the same cycle
//   busy         out  transfer in progress
//   overrun      out  sticky: a trigger arrived while busy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cs high, waiting for a trigger
// SETUP | cs low, CS_SETUP_CYC cycles before the first SCLK low phase
// SHIFT | WORD_BITS SCLK periods, one bit captured at each high-phase end
// HOLD  | one cycle with cs low and sclk low after the last bit
// DONE  | word published, rx_valid high, cs released
module spi_adc_reader
    import spi_pkg::*;
#(
    parameter int WORD_BITS    = ADC_WORD_BITS,
    parameter int CLK_DIV_HALF = SPI_CLK_DIV_HALF,
    parameter int CS_SETUP_CYC = ADC_CS_SETUP_CYC
) (
    input  logic                 clk25,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 auto_en,
    input  logic                 adc_drdy,
    input  logic                 spi_din,
    input  logic                 clr_overrun,
    output logic                 spi_sclk,
    output logic                 adc_cs,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int BIT_W   = $clog2(WORD_BITS);
    localparam int SETUP_W = (CS_SETUP_CYC > 1) ? $clog2(CS_SETUP_CYC) : 1;

    // Reset asserts immediately but releases two clocks later, aligned to clk25.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // drdy idles high, so the synchronizer resets high to avoid a false edge.
    logic drdy_meta;
    logic drdy_sync;
    logic drdy_prev;
    logic din_q;
    logic drdy_fall;
    logic trig;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            drdy_meta <= 1'b1;
            drdy_sync <= 1'b1;
            drdy_prev <= 1'b1;
            din_q     <= 1'b0;
        end else begin
            drdy_meta <= adc_drdy;
            drdy_sync <= drdy_meta;
            drdy_prev <= drdy_sync;
            din_q     <= spi_din;
        end
    end

    assign drdy_fall = auto_en & drdy_prev & ~drdy_sync;
    assign trig      = start | drdy_fall;

    logic clk_en;
    logic sample;
    logic bit_end;

    spi_state_t           state;
    logic [SETUP_W-1:0]   setup_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WORD_BITS-1:0] shreg;

    assign clk_en = (state == ST_SHIFT);

    spi_clk_gen #(
        .CLK_DIV_HALF(CLK_DIV_HALF)
    ) u_clk_gen (
        .clk     (clk25),
        .rst_n   (rst_n),
        .en      (clk_en),
        .sclk    (spi_sclk),
        .sample  (sample),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            setup_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            adc_cs    <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state     <= ST_SETUP;
                        setup_cnt <= SETUP_W'(CS_SETUP_CYC - 1);
                        shreg     <= '0;
                        busy      <= 1'b1;
                        adc_cs    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt == '0) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= BIT_W'(WORD_BITS - 1);
                    end else begin
                        setup_cnt <= setup_cnt - SETUP_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (sample) begin
                        shreg <= {shreg[WORD_BITS-2:0], din_q};
                    end
                    if (bit_end) begin
                        if (bit_cnt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    state    <= ST_DONE;
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                    adc_cs   <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    adc_cs <= 1'b1;
                end
            endcase
        end
    end

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (trig && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Testbench for spi_adc_reader: scoreboard of expected words and completion
// cycles, a serial ADC model that shifts on SCLK falling edges, directed
// scenarios followed by randomized triggers, and a second instance with a
// different parameter set.
module tb_spi_adc_reader;

    localparam int W    = 24;
    localparam int DIV  = 2;
    localparam int SU   = 2;
    localparam int LAT  = 1 + SU + W * 2 * DIV + 1;
    localparam int CSLO = SU + W * 2 * DIV + 1;
    localparam int IDX_W = $clog2(W);

    localparam int W2   = 16;
    localparam int DIV2 = 3;
    localparam int SU2  = 1;
    localparam int LAT2 = 1 + SU2 + W2 * 2 * DIV2 + 1;
    localparam int IDX2_W = $clog2(W2);

    logic clk25 = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic auto_en = 1'b0;
    logic adc_drdy = 1'b1;
    logic spi_din;
    logic clr_overrun = 1'b0;
    logic spi_sclk;
    logic adc_cs;
    logic [W-1:0] rx_data;
    logic rx_valid;
    logic busy;
    logic overrun;

    logic start2 = 1'b0;
    logic spi_din2;
    logic spi_sclk2;
    logic adc_cs2;
    logic [W2-1:0] rx_data2;
    logic rx_valid2;
    logic busy2;
    logic overrun2;

    spi_adc_reader #(.WORD_BITS(W), .CLK_DIV_HALF(DIV), .CS_SETUP_CYC(SU)) dut (
        .clk25(clk25), .reset(reset), .start(start), .auto_en(auto_en),
        .adc_drdy(adc_drdy), .spi_din(spi_din), .clr_overrun(clr_overrun),
        .spi_sclk(spi_sclk), .adc_cs(adc_cs), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .overrun(overrun)
    );

    spi_adc_reader #(.WORD_BITS(W2), .CLK_DIV_HALF(DIV2), .CS_SETUP_CYC(SU2)) dut2 (
        .clk25(clk25), .reset(reset), .start(start2), .auto_en(1'b0),
        .adc_drdy(1'b1), .spi_din(spi_din2), .clr_overrun(1'b0),
        .spi_sclk(spi_sclk2), .adc_cs(adc_cs2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .busy(busy2), .overrun(overrun2)
    );

    always #20 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc++;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int a, input int e);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, a, e, cyc);
    endtask

    // ADC serial models: MSB on cs fall, next bit after every SCLK fall.
    logic [W-1:0]      adc_word = '0;
    logic [IDX_W-1:0]  bit_idx = IDX_W'(W - 1);
    always @(negedge adc_cs) bit_idx = IDX_W'(W - 1);
    always @(negedge spi_sclk) if (!adc_cs && bit_idx != '0) bit_idx = bit_idx - 1'b1;
    assign spi_din = adc_word[bit_idx];

    logic [W2-1:0]     adc_word2 = '0;
    logic [IDX2_W-1:0] bit_idx2 = IDX2_W'(W2 - 1);
    always @(negedge adc_cs2) bit_idx2 = IDX2_W'(W2 - 1);
    always @(negedge spi_sclk2) if (!adc_cs2 && bit_idx2 != '0) bit_idx2 = bit_idx2 - 1'b1;
    assign spi_din2 = adc_word2[bit_idx2];

    int edges = 0;
    always @(posedge spi_sclk) edges++;
    int edges2 = 0;
    always @(posedge spi_sclk2) edges2++;

    // Reference model: a transfer accepted at trigger cycle tc completes at
    // tc+LAT and keeps the block busy through that cycle.
    typedef struct {
        logic [W-1:0] data;
        int           vcyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t exp_e;
    int   busy_until = -1;
    bit   model_ovr = 1'b0;

    task automatic model_trig(input int tc, input logic [W-1:0] d);
        if (tc > busy_until) begin
            sb_q.push_back('{d, tc + LAT});
            busy_until = tc + LAT;
            adc_word = d;
        end else begin
            model_ovr = 1'b1;
        end
    endtask

    // Monitor
    int cs_low = 0;
    int busy_chk_cyc = -10;
    always @(negedge clk25) begin
        if (rx_valid) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_rx_valid", 1, 0);
            end else begin
                exp_e = sb_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(exp_e.data));
                check("valid_cycle", cyc, exp_e.vcyc);
                check("sclk_rises", edges, W);
                check("cs_low_cycles", cs_low, CSLO);
            end
            busy_chk_cyc = cyc + 1;
        end
        if (cyc == busy_chk_cyc) check("busy_after_valid", 32'(busy), 0);
        if (adc_cs) begin
            cs_low = 0;
            edges = 0;
        end else begin
            cs_low++;
        end
    end

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic trigger_at(input int kind, input int tc, input logic [W-1:0] d);
        if (kind == 0) begin
            goto_cycle(tc);
            start = 1'b1;
            model_trig(tc, d);
            step();
            start = 1'b0;
        end else begin
            goto_cycle(tc - 2);
            adc_drdy = 1'b0;
            step();
            adc_drdy = 1'b1;
            goto_cycle(tc);
            if (kind == 2) start = 1'b1;
            model_trig(tc, d);
            step();
            start = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_now("drain_timeout", n, budget);
        step();
    endtask

    task automatic check_clear_ovr(input string name);
        check(name, 32'(overrun), 32'(model_ovr));
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        model_ovr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb_q.delete();
        busy_until = -1;
        model_ovr = 1'b0;
    endtask

    initial begin
        #30000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tc0;
    int n;
    logic [W-1:0] d;

    initial begin
        #5;
        do_reset();
        repeat (3) step();
        check("rst_adc_cs", 32'(adc_cs), 1);
        check("rst_sclk", 32'(spi_sclk), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;
        repeat (4) step();

        // Basic read
        trigger_at(0, cyc, 24'hA5C3F1);
        wait_drain(300);

        // Auto mode: drdy edge starts a read, ignored with auto_en low
        auto_en = 1'b1;
        trigger_at(1, cyc + 2, 24'h000001);
        wait_drain(300);
        auto_en = 1'b0;
        adc_drdy = 1'b0;
        step();
        adc_drdy = 1'b1;
        repeat (6) step();
        check("auto_off_busy", 32'(busy), 0);
        check("auto_off_cs", 32'(adc_cs), 1);
        repeat (LAT) step();

        // Overrun: second start at +40, then clear coinciding with a trigger
        tc0 = cyc;
        trigger_at(0, tc0, 24'h5A5A5A);
        trigger_at(0, tc0 + 40, 24'h111111);
        check("ovr_set", 32'(overrun), 1);
        start = 1'b1;
        clr_overrun = 1'b1;
        model_trig(cyc, 24'h222222);
        step();
        start = 1'b0;
        clr_overrun = 1'b0;
        check("ovr_set_wins", 32'(overrun), 1);
        check_clear_ovr("ovr_cleared");
        check("ovr_clear_value", 32'(overrun), 0);
        wait_drain(300);

        // Reset at SCLK rising edge 10
        trigger_at(0, cyc, 24'hC0FFEE);
        n = 0;
        while (edges < 10 && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) fail_now("sclk10_timeout", n, 400);
        do_reset();
        #1;
        check("midrst_cs", 32'(adc_cs), 1);
        check("midrst_sclk", 32'(spi_sclk), 0);
        check("midrst_rx_data", 32'(rx_data), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (3) step();
        reset = 1'b1;
        repeat (4) step();
        trigger_at(0, cyc, 24'h123456);
        wait_drain(300);

        // Back-to-back, with a rejected trigger in the DONE cycle
        tc0 = cyc;
        trigger_at(0, tc0, 24'hFFFFFF);
        goto_cycle(tc0 + LAT);
        start = 1'b1;
        model_trig(cyc, 24'h333333);
        step();
        model_trig(cyc, 24'h000000);
        step();
        start = 1'b0;
        check_clear_ovr("done_cycle_ovr");
        wait_drain(300);

        // Randomized triggers
        auto_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            d = W'($urandom);
            tc0 = ((busy_until + 1) > (cyc + 2) ? (busy_until + 1) : (cyc + 2)) + $urandom_range(0, 4);
            trigger_at($urandom_range(0, 2), tc0, d);
            if ($urandom_range(0, 2) == 0)
                trigger_at($urandom_range(0, 2), cyc + 3 + $urandom_range(0, 50), W'($urandom));
            goto_cycle(busy_until - 5);
            check_clear_ovr("rand_ovr");
        end
        wait_drain(300);
        check("sb_empty", sb_q.size(), 0);

        // Second parameter set
        adc_word2 = 16'h8001;
        edges2 = 0;
        tc0 = cyc;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        n = 0;
        while (!rx_valid2 && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) fail_now("p2_timeout", n, 400);
        check("p2_latency", cyc - tc0, LAT2);
        check("p2_rx_data", 32'(rx_data2), 32'h8001);
        check("p2_sclk_rises", edges2, W2);
        step();
        check("p2_busy_after", 32'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
